regfile_readback_checker: RTL

REGFILE_READBACK_CHECKER -- requirements
Module: regfile_readback_checker

---
 rtl/regfile_readback_checker_pkg.sv | 16 +
 rtl/regfile_readback_checker_fib_expect_gen.sv | 30 +++
 rtl/regfile_readback_checker.sv | 113 +++++++++++
 3 files changed

// File: rtl/regfile_readback_checker_pkg.sv
// Shared definitions for the register-file readback checker: FSM encoding and
// the default register count / r0 preload value.
package regfile_readback_checker_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEL  = 2'd1,
    CMP  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int          DATA_W       = 16;
  localparam int          NUM_REGS_DEF = 16;
  localparam logic [15:0] INIT_VAL_DEF = 16'h0001;

endpackage

// File: rtl/regfile_readback_checker_fib_expect_gen.sv
// Expected-value generator: holds the pair (exp[k-1], exp[k]) of the
// Fibonacci-style sequence seeded with INIT_VAL; additions wrap mod 2^16.
module fib_expect_gen
  import regfile_readback_checker_pkg::*;
#(
  parameter logic [DATA_W-1:0] INIT_VAL = INIT_VAL_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              advance,
  output logic [DATA_W-1:0] exp_cur
);

  logic [DATA_W-1:0] e_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      e_prev  <= '0;
      exp_cur <= '0;
    end else if (load) begin
      e_prev  <= INIT_VAL;
      exp_cur <= INIT_VAL;
    end else if (advance) begin
      e_prev  <= exp_cur;
      exp_cur <= e_prev + exp_cur;
    end
  end

endmodule

// File: rtl/regfile_readback_checker.sv
// Walks rsel over the register file, comparing each rdata against the
// expected Fibonacci-style sequence and reporting pass / error count / first failure.
module regfile_readback_checker
  import regfile_readback_checker_pkg::*;
#(
  parameter logic [DATA_W-1:0] INIT_VAL = INIT_VAL_DEF,
  parameter int                NUM_REGS = NUM_REGS_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] rdata,
  output logic [3:0]        rsel,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [4:0]        err_count,
  output logic [3:0]        first_fail,
  output logic [DATA_W-1:0] shown,
  output state_t            state_dbg
);

  localparam logic [3:0] LAST_SEL = 4'(NUM_REGS - 1);

  // Handshake: start is a one-cycle request honoured only in IDLE or DONE;
  // done stays high (with pass) until the next accepted start or reset.
  state_t            state, state_n;
  logic [3:0]        rsel_n, first_fail_n;
  logic              busy_n, done_n, pass_n;
  logic [4:0]        err_n;
  logic [DATA_W-1:0] shown_n, exp_cur;
  logic              gen_load, gen_adv;

  fib_expect_gen #(.INIT_VAL(INIT_VAL)) u_gen (
    .clk     (clk),
    .reset   (reset),
    .load    (gen_load),
    .advance (gen_adv),
    .exp_cur (exp_cur)
  );

  always_comb begin
    state_n      = state;
    rsel_n       = rsel;
    busy_n       = busy;
    done_n       = done;
    pass_n       = pass;
    err_n        = err_count;
    first_fail_n = first_fail;
    shown_n      = shown;
    gen_load     = 1'b0;
    gen_adv      = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n      = SEL;
          rsel_n       = 4'd0;
          busy_n       = 1'b1;
          done_n       = 1'b0;
          pass_n       = 1'b0;
          err_n        = 5'd0;
          first_fail_n = 4'd0;
          gen_load     = 1'b1;
        end
      end
      SEL: state_n = CMP;
      CMP: begin
        shown_n = rdata;
        if (rdata != exp_cur) begin
          err_n = err_count + 5'd1;
          if (err_count == 5'd0) first_fail_n = rsel;
        end
        if (rsel == LAST_SEL) begin
          state_n = DONE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          pass_n  = (err_n == 5'd0);
        end else begin
          state_n = SEL;
          rsel_n  = rsel + 4'd1;
          // exp[0] == exp[1], so the pair only starts moving after index 1.
          gen_adv = (rsel != 4'd0);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rsel       <= 4'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= 5'd0;
      first_fail <= 4'd0;
      shown      <= '0;
    end else begin
      state      <= state_n;
      rsel       <= rsel_n;
      busy       <= busy_n;
      done       <= done_n;
      pass       <= pass_n;
      err_count  <= err_n;
      first_fail <= first_fail_n;
      shown      <= shown_n;
    end
  end

  assign state_dbg = state;

endmodule
